act_relu_arb: RTL and testbench

Round-robin arbiter that shares one `leaky_relu` activation unit among `N_REQ` post-accumulator requesters. It accepts one signed value per transaction and drives the unit's `valid`/`x`. It waits for `done`, then returns `y` to the granted requester with a one-hot response strobe. It sits between the convolution accumulators and the single activation instance in the DPU post-processing path.

---
 rtl/act_arb_pkg.sv | 15 +
 rtl/rr_pick.sv | 33 +++
 rtl/act_relu_arb.sv | 135 +++++++++++++
 tb/tb_act_relu_arb.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/act_arb_pkg.sv
// Shared types and default sizes for the leaky_relu request arbiter.
// Imported by rr_pick and act_relu_arb.
package act_arb_pkg;

  localparam int ACT_DATA_W = 32;
  localparam int ACT_N_REQ  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } act_arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: scans last+1 .. last+N (mod N) and
// grants the first asserted request as a one-hot vector plus its index.
module rr_pick #(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] cand;
  logic             found;

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IDX_W'((int'(last) + k) % N);
      if (!found && req[cand]) begin
        gnt[cand] = 1'b1;
        idx       = cand;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/act_relu_arb.sv
// Round-robin arbiter sharing one leaky_relu unit among N_REQ requesters.
// Optional WAIT watchdog enabled by defining ACT_RELU_ARB_TIMEOUT_EN.
module act_relu_arb
  import act_arb_pkg::*;
#(
  parameter  int N_REQ       = ACT_N_REQ,
  parameter  int DATA_W      = ACT_DATA_W,
  parameter  int TIMEOUT_CYC = 16,
  localparam int ID_W        = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_x,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    act_valid,
  output logic [DATA_W-1:0]       act_x,
  input  logic [DATA_W-1:0]       act_y,
  input  logic                    act_done,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_y,
  output logic [ID_W-1:0]         rsp_id,
  output logic                    rsp_err
);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("act_relu_arb: N_REQ must be 2..8 and TIMEOUT_CYC at least 1");
  end

  act_arb_state_t state_q, state_d;

  logic [ID_W-1:0]   last_q, id_q, pick_idx;
  logic [N_REQ-1:0]  pick_gnt;
  logic [DATA_W-1:0] x_q, y_q, x_sel;
  logic              hs;
  logic              tmo;

  rr_pick #(.N(N_REQ)) u_pick (
    .req  (req_valid),
    .last (last_q),
    .gnt  (pick_gnt),
    .idx  (pick_idx)
  );

  // The picker only grants asserted requests, so any grant in IDLE is a handshake.
  assign req_ready = (state_q == IDLE) ? pick_gnt : '0;
  assign hs        = (state_q == IDLE) && (|pick_gnt);

  always_comb begin
    x_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_gnt[i]) x_sel = req_x[i*DATA_W +: DATA_W];
    end
  end

`ifdef ACT_RELU_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  assign tmo = (state_q == WAIT) && !act_done &&
               (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // cnt_q counts completed WAIT cycles; cleared while issuing so it starts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == ISSUE) cnt_q <= '0;
      else if (state_q == WAIT) cnt_q <= cnt_q + CNT_W'(1);
      if (state_q == WAIT) begin
        if (act_done) err_q <= 1'b0;
        else if (tmo) err_q <= 1'b1;
      end
    end
  end

  assign rsp_err = (state_q == RESP) && err_q;
`else
  assign tmo     = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hs) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (act_done || tmo) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Data registers are reset too, since act_x exposes x_q directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= ID_W'(N_REQ - 1);
      id_q   <= '0;
      x_q    <= '0;
      y_q    <= '0;
    end else begin
      if (hs) begin
        x_q    <= x_sel;
        id_q   <= pick_idx;
        last_q <= pick_idx;
      end
      if (state_q == WAIT) begin
        if (act_done) y_q <= act_y;
        else if (tmo) y_q <= '0;
      end
    end
  end

  assign act_valid = (state_q == ISSUE);
  assign act_x     = x_q;

  always_comb begin
    rsp_valid = '0;
    if (state_q == RESP) rsp_valid[id_q] = 1'b1;
  end

  assign rsp_y  = (state_q == RESP) ? y_q  : '0;
  assign rsp_id = (state_q == RESP) ? id_q : '0;

endmodule

// File: tb/tb_act_relu_arb.sv
// Self-checking bench for act_relu_arb: behavioural leaky_relu stub plus a
// transaction-level round-robin reference model with randomized traffic.
module tb_act_relu_arb;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int TMO = 16;
  localparam int IW  = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_valid, req_ready, rsp_valid;
  logic [N*DW-1:0] req_x;
  logic          act_valid, act_done, rsp_err;
  logic [DW-1:0] act_x, act_y, rsp_y;
  logic [IW-1:0] rsp_id;

  logic [DW-1:0] rx [N];
  int            n_vec  = 0;
  int            n_miss = 0;
  int            last_m;
  int            stub_lat  = 1;
  bit            stub_hang = 1'b0;
  int            stub_cnt;
  logic [DW-1:0] stub_hold;

  always #5 clk = ~clk;

  always_comb begin
    req_x = '0;
    for (int i = 0; i < N; i++) req_x[i*DW +: DW] = rx[i];
  end

  act_relu_arb #(.N_REQ(N), .DATA_W(DW), .TIMEOUT_CYC(TMO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_x     (req_x),
    .req_ready (req_ready),
    .act_valid (act_valid),
    .act_x     (act_x),
    .act_y     (act_y),
    .act_done  (act_done),
    .rsp_valid (rsp_valid),
    .rsp_y     (rsp_y),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err)
  );

  // y = x for x >= 0, else floor(x / 8)
  function automatic logic [DW-1:0] relu_ref(input logic [DW-1:0] x);
    longint sx;
    sx = $signed(x);
    if (sx >= 0) return x;
    sx = (sx - 7) / 8;
    return DW'(sx);
  endfunction

  function automatic logic [DW-1:0] random_x();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'h7fff_ffff;
      2:       return 32'hffff_ffff;
      3:       return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  function automatic int pick_ref();
    for (int k = 1; k <= N; k++) begin
      if (req_valid[(last_m + k) % N]) return (last_m + k) % N;
    end
    return -1;
  endfunction

  // leaky_relu stand-in: done arrives stub_lat cycles after valid, or never.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_done <= 1'b0;
      act_y    <= '0;
      stub_cnt <= 0;
    end else begin
      act_done <= 1'b0;
      act_y    <= $urandom;
      if (act_valid && !stub_hang) begin
        if (stub_lat <= 1) begin
          act_done <= 1'b1;
          act_y    <= relu_ref(act_x);
        end else begin
          stub_cnt  <= stub_lat - 1;
          stub_hold <= relu_ref(act_x);
        end
      end else if (stub_cnt > 0) begin
        stub_cnt <= stub_cnt - 1;
        if (stub_cnt == 1) begin
          act_done <= 1'b1;
          act_y    <= stub_hold;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_act_valid"}, act_valid, 0);
    check({tag, "_act_x"},     act_x,     0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_y"},     rsp_y,     0);
    check({tag, "_rsp_id"},    rsp_id,    0);
    check({tag, "_rsp_err"},   rsp_err,   0);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    stub_hang = 1'b0;
    #1;
    check_outputs_zero("reset");
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    last_m = N - 1;
  endtask

  // One transaction from the current IDLE negedge through its response.
  // mode: 0 = served requester drops, 1 = keeps requesting with new x, 2 = random.
  task automatic serve(input int lat, input bit hang, input int mode);
    int            id;
    int            waits;
    int            exp_waits;
    bit            got_rsp;
    logic [DW-1:0] xe, ye;
    logic          ee;
    #1;
    id = pick_ref();
    if (id < 0) return;
    stub_lat  = lat;
    stub_hang = hang;
    check("grant", req_ready, 64'(1) << id);
    xe     = rx[id];
    last_m = id;
    @(negedge clk);
    check("issue_act_valid", act_valid, 1);
    check("issue_act_x",     act_x,     xe);
    check("issue_ready",     req_ready, 0);
    rx[id] = random_x();
    if (mode == 0)      req_valid[id] = 1'b0;
    else if (mode == 2) req_valid[id] = 1'($urandom_range(0, 1));
    waits   = 0;
    got_rsp = 1'b0;
    for (int c = 0; c < 60 && !got_rsp; c++) begin
      @(negedge clk);
      if (rsp_valid != '0) got_rsp = 1'b1;
      else begin
        waits++;
        check("wait_ready",     req_ready, 0);
        check("wait_act_valid", act_valid, 0);
        check("wait_act_x",     act_x,     xe);
        check("wait_rsp_y",     rsp_y,     0);
      end
    end
`ifdef ACT_RELU_ARB_TIMEOUT_EN
    exp_waits = hang ? TMO : lat;
    ye        = hang ? '0 : relu_ref(xe);
    ee        = hang;
`else
    if (hang) begin
      check("hang_no_rsp", got_rsp, 0);
      return;
    end
    exp_waits = lat;
    ye        = relu_ref(xe);
    ee        = 1'b0;
`endif
    check("rsp_seen",    got_rsp,   1);
    check("wait_cycles", waits,     exp_waits);
    check("rsp_valid",   rsp_valid, 64'(1) << id);
    check("rsp_y",       rsp_y,     ye);
    check("rsp_id",      rsp_id,    id);
    check("rsp_err",     rsp_err,   ee);
    @(negedge clk);
    check("post_rsp_valid", rsp_valid, 0);
    check("post_rsp_y",     rsp_y,     0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    for (int i = 0; i < N; i++) rx[i] = '0;
    @(negedge clk);
    do_reset();

    // No requests: nothing granted or issued.
    repeat (3) begin
      @(negedge clk);
      check("idle_ready",     req_ready, 0);
      check("idle_act_valid", act_valid, 0);
      check("idle_rsp_valid", rsp_valid, 0);
    end

    // Requester 0 alone, x = -80.
    rx[0]        = -32'sd80;
    req_valid[0] = 1'b1;
    serve(1, 1'b0, 0);

    // Requesters 0,1,2 together from reset: served 0,1,2.
    do_reset();
    rx[0] = 32'sd40;
    rx[1] = -32'sd8;
    rx[2] = 32'sd0;
    req_valid = 4'b0111;
    repeat (3) serve(1, 1'b0, 0);

    // All four held valid across eight transactions.
    do_reset();
    for (int i = 0; i < N; i++) rx[i] = random_x();
    req_valid = 4'b1111;
    repeat (8) serve(1, 1'b0, 1);
    req_valid = '0;

    // Randomized masks, data and done latency.
    for (int t = 0; t < 40; t++) begin
      for (int g = 0; g < 8 && req_valid == '0; g++) begin
        req_valid = 4'($urandom_range(0, 15));
        for (int i = 0; i < N; i++) if (!req_valid[i]) rx[i] = random_x();
        if (req_valid == '0) begin
          #1;
          check("rand_idle_ready", req_ready, 0);
          @(negedge clk);
        end
      end
      serve($urandom_range(1, 3), 1'b0, 2);
    end

    // Reset while waiting on done abandons the transaction.
    do_reset();
    rx[2]        = random_x();
    req_valid    = 4'b0100;
    stub_hang    = 1'b1;
    #1;
    check("rstw_grant", req_ready, 4'b0100);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("rst_in_wait");
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    stub_hang = 1'b0;
    last_m    = N - 1;
    repeat (4) begin
      @(negedge clk);
      check("rstw_no_rsp",   rsp_valid, 0);
      check("rstw_no_issue", act_valid, 0);
    end
    for (int i = 0; i < N; i++) rx[i] = random_x();
    req_valid = 4'b1111;
    serve(1, 1'b0, 0);
    req_valid = '0;

    // Unit that never completes.
    do_reset();
    rx[1]        = random_x();
    req_valid[1] = 1'b1;
    serve(1, 1'b1, 0);
    stub_hang = 1'b0;
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
